// File: rtl/axi_frame_writer.sv
// axi_frame_writer
//   AXI3 write master that captures a 24-bit pixel stream into a linear frame
//   buffer. Pixels are packed one per 32-bit word ({8'h00, R, G, B}), queued in
//   a first-word-fall-through FIFO of 2*BURST_LEN words, and written as
//   fixed-length INCR bursts with a single burst outstanding.
//
//   Optional feature macro: AXI_WR_BRESP_CHECK_EN
//     defined   -> a B handshake with BRESP != OKAY sets the sticky RespErr.
//     undefined -> RespErr is tied low and BRESP is ignored.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   PixValid/PixReady/PixData/PixSof  pixel stream in (PixSof marks word 0)
//   AW*                           write address channel (AWID/AWLEN/... fixed)
//   W*                            write data channel (WID/WSTRB fixed)
//   B*                            write response channel (BID ignored)
//   FrameDone                     1-cycle pulse on the B handshake of a frame's last burst
//   FrameErr                      sticky, PixSof seen mid-frame
//   RespErr                       sticky, BRESP error (feature macro only)
module axi_frame_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          H_ACTIVE  = 1280,
    parameter int          V_ACTIVE  = 720,
    parameter int          BURST_LEN = 16
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        PixValid,
    output logic        PixReady,
    input  logic [23:0] PixData,
    input  logic        PixSof,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic [1:0]  AWLOCK,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [3:0]  WID,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic        FrameDone,
    output logic        FrameErr,
    output logic        RespErr
);

    localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
    localparam int NBURST = TOTAL / BURST_LEN;
    localparam int DEPTH  = 2 * BURST_LEN;
    localparam int PCW    = (TOTAL > 1)     ? $clog2(TOTAL)     : 1;
    localparam int BCW    = (NBURST > 1)    ? $clog2(NBURST)    : 1;
    localparam int BTW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int LW     = $clog2(DEPTH + 1);

    localparam logic [PCW-1:0] PIX_LAST   = PCW'(TOTAL - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(NBURST - 1);
    localparam logic [BTW-1:0] BEAT_LAST  = BTW'(BURST_LEN - 1);
    localparam logic [PW-1:0]  PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [31:0]    ADDR_STEP  = 32'(BURST_LEN * 4);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t         state, state_nx;
    logic           rst_done;
    logic           synced;
    logic [PCW-1:0] pixcnt;
    logic           frame_err;
    logic [23:0]    mem [DEPTH];
    logic [PW-1:0]  wptr, rptr;
    logic [LW-1:0]  level;
    logic           full, accept, push, pop;
    logic [BTW-1:0] beat;
    logic [BCW-1:0] burstcnt;
    logic [31:0]    addr;
    logic           b_hs, last_burst;

    // Fixed AXI attributes
    assign AWID    = 4'h0;
    assign AWLEN   = 4'(BURST_LEN - 1);
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWLOCK  = 2'b00;
    assign WID     = 4'h0;
    assign WSTRB   = 4'hF;
    assign AWADDR  = addr;
    assign WDATA   = {8'h00, mem[rptr]};

    // Hold off the pixel source until the first clock after reset release
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    assign full     = (level == LW'(DEPTH));
    assign PixReady = rst_done && !full;
    assign accept   = PixValid && PixReady;
    // While unsynced, everything but a SOF pixel is accepted and dropped
    assign push     = accept && (synced || PixSof);
    assign pop      = WVALID && WREADY;

    // Frame sync and pixel counter. An unsynced SOF behaves as pixel 0; a SOF
    // while synced past pixel 0 only flags an error and counting carries on.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            synced    <= 1'b0;
            pixcnt    <= '0;
            frame_err <= 1'b0;
        end else if (push) begin
            if (synced && PixSof && pixcnt != '0) frame_err <= 1'b1;
            if (pixcnt == PIX_LAST) begin
                pixcnt <= '0;
                synced <= 1'b0;
            end else begin
                pixcnt <= pixcnt + PCW'(1);
                synced <= 1'b1;
            end
        end
    end
    assign FrameErr = frame_err;

    // FIFO storage needs no reset; pointers and level carry the state
    always_ff @(posedge ACLK) begin
        if (push) mem[wptr] <= PixData;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Write FSM: state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Write FSM: next state and channel strobes. A burst is only started once
    // a full burst is buffered, so DATA never waits on the FIFO.
    always_comb begin
        state_nx = state;
        AWVALID  = 1'b0;
        WVALID   = 1'b0;
        WLAST    = 1'b0;
        BREADY   = 1'b0;
        case (state)
            S_IDLE: if (level >= LW'(BURST_LEN)) state_nx = S_ADDR;
            S_ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) state_nx = S_DATA;
            end
            S_DATA: begin
                WVALID = 1'b1;
                WLAST  = (beat == BEAT_LAST);
                if (WREADY && beat == BEAT_LAST) state_nx = S_RESP;
            end
            S_RESP: begin
                BREADY = 1'b1;
                if (BVALID) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign b_hs       = (state == S_RESP) && BVALID;
    assign last_burst = (burstcnt == BURST_LAST);
    assign FrameDone  = b_hs && last_burst;

    // Beat counter, burst counter and address, all advanced by handshakes
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beat     <= '0;
            burstcnt <= '0;
            addr     <= BASE_ADDR;
        end else begin
            if (pop) beat <= (beat == BEAT_LAST) ? '0 : beat + BTW'(1);
            if (b_hs) begin
                if (last_burst) begin
                    burstcnt <= '0;
                    addr     <= BASE_ADDR;
                end else begin
                    burstcnt <= burstcnt + BCW'(1);
                    addr     <= addr + ADDR_STEP;
                end
            end
        end
    end

`ifdef AXI_WR_BRESP_CHECK_EN
    logic resp_err;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                    resp_err <= 1'b0;
        else if (b_hs && BRESP != 2'b00) resp_err <= 1'b1;
    end
    assign RespErr = resp_err;

    logic unused_in;
    assign unused_in = ^BID;
`else
    assign RespErr = 1'b0;

    logic unused_in;
    assign unused_in = ^{BID, BRESP};
`endif

endmodule

// File: tb/tb_axi_frame_writer.sv
// tb_axi_frame_writer
//   Directed sequence with randomized pixel data and AXI slave timing for
//   axi_frame_writer (4x4 frame, 4-beat bursts). A negedge monitor keeps a
//   queue of words that should reach memory, the burst/frame tallies and the
//   error flags, and checks every channel event against them.
module tb_axi_frame_writer;

    localparam int          H     = 4;
    localparam int          V     = 4;
    localparam int          BL    = 4;
    localparam int          NB    = H * V / BL;
    localparam int          DEPTH = 2 * BL;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        ACLK, ARESETn;
    logic        PixValid, PixReady, PixSof;
    logic [23:0] PixData;
    logic [3:0]  AWID, AWLEN, WID, WSTRB, BID;
    logic [31:0] AWADDR, WDATA;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST, AWLOCK, BRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        FrameDone, FrameErr, RespErr;

    axi_frame_writer #(.BASE_ADDR(BASE), .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .PixValid(PixValid), .PixReady(PixReady), .PixData(PixData), .PixSof(PixSof),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .FrameDone(FrameDone), .FrameErr(FrameErr), .RespErr(RespErr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] aw_log[$];
    bit          mon_en = 0;
    bit          m_sync = 0, m_ferr = 0, m_rerr = 0;
    int          m_cnt = 0;
    int          aw_cnt = 0, w_bursts = 0, beat = 0, b_cnt = 0, frames = 0, fd_seen = 0;
    bit          saw_full = 0;
    bit          aw_hold = 0, w_hold = 0;
    logic [31:0] aw_prev = '0, w_prev = '0;

    // Slave-side shared state
    int  bpend = 0, b_issue = 0, resp_bad = -1;
    bit  b_clear = 0, wr_hold = 0;

    always @(negedge ACLK) begin
        if (mon_en) begin
            logic [31:0] exp_w;
            chk("PixReady", PixReady, q.size() < DEPTH);
            chk("FrameErr", FrameErr, m_ferr);
            chk("RespErr", RespErr, m_rerr);
            chk("FrameDone", FrameDone, BVALID && BREADY && ((b_cnt + 1) % NB == 0));
            chk("WLAST", WLAST, WVALID && (beat == BL - 1));
            if (aw_hold) begin
                chk("AWVALID_hold", AWVALID, 1);
                chk("AWADDR_hold", AWADDR, aw_prev);
            end
            if (w_hold) begin
                chk("WVALID_hold", WVALID, 1);
                chk("WDATA_hold", WDATA, w_prev);
            end
            if (WVALID) chk("W_after_AW", aw_cnt > w_bursts, 1);
            if (FrameDone) fd_seen++;
            if (!PixReady) saw_full = 1;

            if (AWVALID && AWREADY) begin
                chk("AWADDR", AWADDR, BASE + 32'((aw_cnt % NB) * BL * 4));
                chk("AWLEN", AWLEN, BL - 1);
                chk("AWSIZE", AWSIZE, 3'b010);
                chk("AWBURST", AWBURST, 2'b01);
                aw_log.push_back(AWADDR);
                aw_cnt++;
            end
            if (WVALID && WREADY) begin
                if (q.size() == 0) chk("W_no_data", 1, 0);
                else begin
                    exp_w = q.pop_front();
                    chk("WDATA", WDATA, exp_w);
                end
                chk("WSTRB", WSTRB, 4'hF);
                beat++;
                if (beat == BL) begin
                    beat = 0;
                    w_bursts++;
                    bpend++;
                end
            end
            if (BVALID && BREADY) begin
`ifdef AXI_WR_BRESP_CHECK_EN
                if (BRESP != 2'b00) m_rerr = 1;
`endif
                b_cnt++;
                if (b_cnt % NB == 0) frames++;
                b_clear = 1;
            end
            if (PixValid && PixReady && (m_sync || PixSof)) begin
                if (m_sync && PixSof && m_cnt != 0) m_ferr = 1;
                q.push_back({8'h00, PixData});
                m_cnt++;
                m_sync = 1;
                if (m_cnt == H * V) begin
                    m_cnt = 0;
                    m_sync = 0;
                end
            end
            aw_hold = AWVALID && !AWREADY;
            aw_prev = AWADDR;
            w_hold  = WVALID && !WREADY;
            w_prev  = WDATA;
        end
    end

    // Randomized AXI slave
    always @(posedge ACLK) begin
        #1;
        AWREADY = ($urandom_range(0, 2) != 0);
        WREADY  = wr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (b_clear) begin
            BVALID  = 1'b0;
            BRESP   = 2'b00;
            b_clear = 0;
        end
        if (!BVALID && bpend > 0 && $urandom_range(0, 1) == 1) begin
            BVALID = 1'b1;
            BRESP  = (b_issue == resp_bad) ? 2'b10 : 2'b00;
            b_issue++;
            bpend--;
        end
    end

    task automatic send_px(input logic [23:0] d, input bit sof, input bit gap);
        bit hs = 0;
        int n = 0;
        if (gap && $urandom_range(0, 3) == 0) begin
            PixValid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge ACLK); #1; end
        end
        PixValid = 1'b1;
        PixData  = d;
        PixSof   = sof;
        while (!hs && n < 200) begin
            @(negedge ACLK);
            hs = PixReady;
            @(posedge ACLK);
            #1;
            n++;
        end
        if (!hs) chk("pix_timeout", 0, 1);
        PixValid = 1'b0;
        PixSof   = 1'b0;
    endtask

    task automatic send_frame(input int n, input int sof_extra, input bit rnd, input bit gap);
        for (int i = 0; i < n; i++)
            send_px(rnd ? 24'($urandom) : 24'(i), (i % (H * V) == 0) || (i == sof_extra), gap);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 3000) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        chk("frame_timeout", frames >= target, 1);
        chk("framedone_count", fd_seen, target);
    endtask

    initial begin
        int rec;
        ARESETn  = 1'b0;
        PixValid = 1'b0;
        PixSof   = 1'b0;
        PixData  = '0;
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        BRESP    = 2'b00;
        BID      = 4'h0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_AWVALID", AWVALID, 0);
        chk("rst_WVALID", WVALID, 0);
        chk("rst_WLAST", WLAST, 0);
        chk("rst_BREADY", BREADY, 0);
        chk("rst_FrameDone", FrameDone, 0);
        chk("rst_FrameErr", FrameErr, 0);
        chk("rst_RespErr", RespErr, 0);
        chk("rst_AWADDR", AWADDR, BASE);
        chk("rst_PixReady", PixReady, 0);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        mon_en = 1;

        // Pixels before the first SOF are discarded
        for (int i = 0; i < 5; i++) send_px(24'($urandom) | 24'h800000, 1'b0, 1'b0);
        repeat (10) @(posedge ACLK);
        #1;
        chk("no_aw_before_sof", aw_cnt, 0);
        chk("nothing_buffered", q.size(), 0);

        // Frame of pixels 0..15
        send_frame(16, -1, 1'b0, 1'b0);
        wait_frames(1);

        // W channel stalled 20 cycles with continuous input: FIFO must fill
        saw_full = 0;
        fork
            begin
                wr_hold = 1;
                repeat (20) @(posedge ACLK);
                #1;
                wr_hold = 0;
            end
            send_frame(16, -1, 1'b1, 1'b0);
        join
        wait_frames(2);
        chk("fifo_filled", saw_full, 1);

        // Two frames back to back: second frame restarts at BASE
        rec = aw_cnt;
        send_frame(2 * H * V, -1, 1'b1, 1'b1);
        wait_frames(4);
        chk("frame2_base", aw_log[rec + NB], BASE);

        // SOF mid-frame sets FrameErr, frame length unchanged, flag sticky
        send_frame(16, 6, 1'b1, 1'b1);
        wait_frames(5);
        chk("frameerr_set", FrameErr, 1);
        send_frame(16, -1, 1'b1, 1'b0);
        wait_frames(6);
        chk("frameerr_sticky", FrameErr, 1);

        // SLVERR on the second burst of the next frame
        resp_bad = b_issue + 1;
        send_frame(16, -1, 1'b1, 1'b1);
        wait_frames(7);
        chk("bursts_total", b_cnt, 7 * NB);
`ifdef AXI_WR_BRESP_CHECK_EN
        chk("resperr_set", RespErr, 1);
`else
        chk("resperr_off", RespErr, 0);
`endif

        repeat (5) @(posedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_frame_writer.md
# axi_frame_writer

AXI3 write master that captures a 24-bit pixel stream into a linear frame buffer in memory. It is the write-side counterpart of the video read path, which fetches frames over AXI3 for the VGA/TMDS output. Pixels are packed one per 32-bit word, buffered in an internal FIFO, and written as fixed-length INCR bursts with one burst outstanding. A single clock domain is used: the pixel source runs on ACLK.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of frame word 0; must be 4-byte aligned.
- H_ACTIVE, 1280: pixels per line.
- V_ACTIVE, 720: lines per frame. H_ACTIVE*V_ACTIVE must be a multiple of BURST_LEN.
- BURST_LEN, 16: beats per burst, 1..16.

Ports:
- ACLK  in  1  sole clock.
- ARESETn  in  1  reset; asynchronous, active-low.
- PixValid  in  1  pixel present.
- PixReady  out  1  pixel accepted when PixValid && PixReady.
- PixData  in  24  {R,G,B}.
- PixSof  in  1  qualifies the current pixel as the first of a frame.
- AWID  out  4  constant 0.
- AWADDR  out  32  burst start address.
- AWLEN  out  4  constant BURST_LEN-1.
- AWSIZE  out  3  constant 3'b010.
- AWBURST  out  2  constant 2'b01 (INCR).
- AWLOCK  out  2  constant 0.
- AWVALID / AWREADY  out / in  1  AW handshake.
- WID  out  4  constant 0.
- WDATA  out  32  {8'h00, PixData}.
- WSTRB  out  4  constant 4'hF.
- WLAST  out  1  final beat of burst.
- WVALID / WREADY  out / in  1  W handshake.
- BID  in  4  ignored.
- BRESP  in  2  write response.
- BVALID / BREADY  in / out  1  B handshake.
- FrameDone  out  1  one-cycle pulse on the B handshake of a frame's last burst.
- FrameErr  out  1  sticky; set on a PixSof arriving mid-frame.
- RespErr  out  1  sticky BRESP error flag; see Configuration.

## Operation
- Sync: after reset, the block discards accepted pixels (PixReady=1, no FIFO write) until a pixel with PixSof is accepted. That pixel is word 0 of the frame.
- Pixel counter: 0..H_ACTIVE*V_ACTIVE-1, counts FIFO writes. After the final pixel, the block returns to sync and waits for the next PixSof.
- PixSof with counter != 0 while synced: FrameErr is set. The pixel is written as an ordinary pixel and counting continues; there is no resync.
- FIFO: depth 2*BURST_LEN, first-word fall-through. PixReady = rst_done && !full. rst_done is a register that resets to 0 and sets on the first ACLK after ARESETn rises.
- Write FSM:
  - IDLE: if FIFO level >= BURST_LEN, go to ADDR.
  - ADDR: AWVALID=1; on AWREADY go to DATA.
  - DATA: WVALID=1, WDATA taken from the FIFO head, and the FIFO pops on each W handshake. WLAST=1 when beat count == BURST_LEN-1. On the WLAST handshake go to RESP.
  - RESP: BREADY=1; on BVALID go to IDLE.
- Address: AWADDR starts at BASE_ADDR. It advances by BURST_LEN*4 on each B handshake. After the burst that ends the frame, it wraps to BASE_ADDR.
- Burst counter: derived from the burst count per frame, H_ACTIVE*V_ACTIVE/BURST_LEN. FrameDone pulses on the B handshake of the final burst.
- Pixels are written in both DATA and other states; simultaneous push and pop leaves the level unchanged.

## Timing
- Reset values:
  - AWVALID, WVALID, WLAST, BREADY, FrameDone, FrameErr, RespErr: all 0.
  - AWADDR = BASE_ADDR.
  - PixReady = 0.
  - FIFO empty, FSM in IDLE, unsynced.
- Level visibility: the FIFO level updates the cycle after a push. AWVALID asserts at the earliest 2 cycles after the BURST_LEN-th buffered pixel is accepted.
- AXI valid signals: AWVALID and WVALID are held until their ready; AWADDR and WDATA are stable while valid is high and ready is low.
- W after AW: W is never issued before the AW handshake. WVALID rises the cycle after the AW handshake.
- Back-to-back bursts: minimum gap from B handshake to next AWVALID is 1 cycle (the IDLE cycle).
- Full FIFO: PixReady=0, so there is no overflow and no pixel loss.
- Reset mid-burst: all state clears immediately. The in-flight burst is abandoned; the interconnect is reset together.

## Configuration
- AXI_WR_BRESP_CHECK_EN defined: a B handshake with BRESP != 2'b00 sets RespErr (sticky until reset). Address advance and FrameDone are unaffected.
- Not defined: RespErr is tied to 0 and BRESP is ignored.

## Test plan
- Reset release, H_ACTIVE=4, V_ACTIVE=4, BURST_LEN=4, 16 pixels 0..15 with PixSof on pixel 0 -> 4 bursts at BASE+0x00/0x10/0x20/0x30, AWLEN=3, WDATA=32'h0000_000n, and one FrameDone on the 4th B.
- 5 pixels before the first PixSof -> discarded, no AW issued, and the first burst carries the post-SOF pixels only.
- WREADY held low 20 cycles with continuous input -> PixReady falls when 8 words are buffered, no data lost or reordered, and WDATA/WVALID stable.
- Two frames back-to-back -> the second frame's first AWADDR == BASE_ADDR, and FrameDone pulses twice.
- PixSof on pixel 6 of a 16-pixel frame -> FrameErr=1 and sticky, and the frame still completes at original count.
- With AXI_WR_BRESP_CHECK_EN, BRESP=2'b10 on burst 2 -> RespErr=1 and the remaining bursts complete. Without the macro -> RespErr stays 0.
